// File: rtl/col_gather_pipe.sv
// col_gather_pipe
// Two-stage lane selector between the operand buffer and the PE array.
// Each input beat carries M lanes and a mode. The mode picks how the N output
// lanes are filled: straight pass, rotate by col, sparse gather by per-lane
// idx, or broadcast of lane col. Stage 1 captures the beat together with
// precomputed per-lane source selects and in-range flags. Stage 2 performs the
// lane mux and zeroes out-of-range lanes. A valid/ready handshake on both
// sides keeps one beat per cycle flowing while the downstream is ready.

module col_gather_pipe #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int DW_POS  = 4,
  parameter int DW_DATA = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [DW_POS-1:0]      col,
  input  logic [N*DW_POS-1:0]    idx,
  input  logic [M*DW_DATA-1:0]   in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*DW_DATA-1:0]   out,
  output logic [N-1:0]           out_mask
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_GATHER = 2'd2,
    MODE_BCAST  = 2'd3
  } mode_t;

  typedef logic [DW_POS-1:0] pos_t;
  typedef logic [DW_POS:0]   pos_ext_t;

  // One extra bit so that M == 2**DW_POS still compares correctly.
  localparam pos_ext_t M_EXT = pos_ext_t'(M);

  // Handshake and pipeline occupancy
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic s1_advance;

  // Stage-1 payload
  mode_t              s1_mode;
  logic [DW_DATA-1:0] s1_lane [M];
  pos_t               s1_sel  [N];
  logic [N-1:0]       s1_inr;

  // Stage-1 next values derived from the incoming beat
  pos_t               sel_d [N];
  logic [N-1:0]       inr_d;

  // Stage-2 next value and registered outputs
  logic [N*DW_DATA-1:0] out_d;
  logic [N*DW_DATA-1:0] out_q;
  logic [N-1:0]         mask_q;

  assign s2_free    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_free;
  assign in_ready   = !rst && (!s1_valid || s2_free);

  // Per-output-lane source select and in-range flag for the incoming beat
  always_comb begin : sel_calc
    pos_ext_t rot_sum;
    pos_t     idx_lane;
    rot_sum  = '0;
    idx_lane = '0;
    for (int j = 0; j < N; j++) begin
      sel_d[j] = '0;
      inr_d[j] = 1'b0;
      idx_lane = idx[j*DW_POS +: DW_POS];
      rot_sum  = pos_ext_t'(j) + {1'b0, col};
      case (mode_t'(mode))
        MODE_PASS: begin
          sel_d[j] = pos_t'(j);
          inr_d[j] = 1'b1;
        end
        MODE_ROTATE: begin
          sel_d[j] = pos_t'(rot_sum % M_EXT);
          inr_d[j] = 1'b1;
        end
        MODE_GATHER: begin
          if ({1'b0, idx_lane} < M_EXT) begin
            sel_d[j] = idx_lane;
            inr_d[j] = 1'b1;
          end
        end
        MODE_BCAST: begin
          if ({1'b0, col} < M_EXT) begin
            sel_d[j] = col;
            inr_d[j] = 1'b1;
          end
        end
      endcase
    end
  end

  // Stage-1 occupancy: refill whenever the slot is empty or handing its beat on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage-1 payload capture; mode/col/idx only matter on an input transfer
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_mode <= mode_t'(mode);
      s1_inr  <= inr_d;
      for (int i = 0; i < M; i++) begin
        s1_lane[i] <= in[i*DW_DATA +: DW_DATA];
      end
      for (int j = 0; j < N; j++) begin
        s1_sel[j] <= sel_d[j];
      end
    end
  end

  // Stage-2 lane mux; pass beats skip the select mux, out-of-range lanes are zeroed
  always_comb begin : lane_mux
    logic [DW_DATA-1:0] picked;
    picked = '0;
    out_d  = '0;
    for (int j = 0; j < N; j++) begin
      picked = '0;
      if (s1_mode == MODE_PASS) begin
        picked = s1_lane[j];
      end else begin
        for (int k = 0; k < M; k++) begin
          if (s1_sel[j] == pos_t'(k)) begin
            picked = s1_lane[k];
          end
        end
      end
      out_d[j*DW_DATA +: DW_DATA] = s1_inr[j] ? picked : '0;
    end
  end

  // Stage-2 register: loads from stage 1 when free, otherwise holds under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_q    <= '0;
      mask_q   <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_advance;
      if (s1_advance) begin
        out_q  <= out_d;
        mask_q <= s1_inr;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out       = out_q;
  assign out_mask  = mask_q;

endmodule

// File: tb/tb_col_gather_pipe.sv
// tb_col_gather_pipe
// Self-checking bench for col_gather_pipe with default parameters. Directed
// scenarios use hand-computed constants; randomized traffic is checked against
// a lane-level reference model that predicts each accepted beat's output.

module tb_col_gather_pipe;

  localparam int M       = 4;
  localparam int N       = 4;
  localparam int DW_POS  = 4;
  localparam int DW_DATA = 8;
  localparam int IW      = M*DW_DATA;
  localparam int OW      = N*DW_DATA;
  localparam int XW      = N*DW_POS;

  localparam logic [IW-1:0] BASE_IN = 32'h03020104;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [DW_POS-1:0] col;
  logic [XW-1:0]     idx;
  logic [IW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic [N-1:0]      out_mask;

  int n_checks;
  int n_fail;

  logic [N+OW-1:0] exp_q [$];

  col_gather_pipe #(
    .M(M), .N(N), .DW_POS(DW_POS), .DW_DATA(DW_DATA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .col(col),
    .idx(idx),
    .in(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out_data),
    .out_mask(out_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "[TB] timeout");
  end

  // Expected {mask, out} for one beat, straight from the lane rules
  function automatic logic [N+OW-1:0] model(input logic [1:0] md, input logic [DW_POS-1:0] c,
                                            input logic [XW-1:0] ix, input logic [IW-1:0] d);
    logic [OW-1:0] o;
    logic [N-1:0]  m;
    int s;
    int cv;
    int iv;
    bit ok;
    o  = '0;
    m  = '0;
    cv = int'(c);
    for (int j = 0; j < N; j++) begin
      iv = int'(ix[j*DW_POS +: DW_POS]);
      case (md)
        2'd0:    begin s = j;            ok = 1'b1; end
        2'd1:    begin s = (j + cv) % M; ok = 1'b1; end
        2'd2:    begin ok = (iv < M); s = ok ? iv : 0; end
        default: begin ok = (cv < M); s = ok ? cv : 0; end
      endcase
      m[j] = ok;
      if (ok) o[j*DW_DATA +: DW_DATA] = d[s*DW_DATA +: DW_DATA];
    end
    return {m, o};
  endfunction

  // One clock: sample handshakes away from the edge, log accepted beats in the model queue
  task automatic step(output logic acc, output logic ov, output logic [OW-1:0] o, output logic [N-1:0] m);
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    o   = out_data;
    m   = out_mask;
    if (acc) exp_q.push_back(model(mode, col, idx, in_data));
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    mode    = 2'($urandom_range(0, 3));
    col     = DW_POS'($urandom_range(0, 15));
    for (int j = 0; j < N; j++) idx[j*DW_POS +: DW_POS] = DW_POS'($urandom_range(0, 7));
    in_data = IW'($urandom);
  endtask

  // Send a single beat into an empty pipe and wait for it to come out
  task automatic send_one(input logic [1:0] md, input logic [DW_POS-1:0] c, input logic [XW-1:0] ix,
                          input logic [IW-1:0] d, output bit acc_ok, output int lat,
                          output logic [OW-1:0] o, output logic [N-1:0] m, output logic [N+OW-1:0] e);
    logic acc, ov;
    logic [OW-1:0] so;
    logic [N-1:0]  sm;
    exp_q.delete();
    mode = md; col = c; idx = ix; in_data = d;
    in_valid = 1'b1; out_ready = 1'b1;
    step(acc, ov, so, sm);
    acc_ok = acc;
    in_valid = 1'b0;
    lat = -1; o = '0; m = '0; e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    for (int cyc = 1; cyc <= 8 && lat < 0; cyc++) begin
      step(acc, ov, so, sm);
      if (ov) begin lat = cyc; o = so; m = sm; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if ({out_mask, out_data} !== '0) begin n_fail++; $display("[TB] FAIL reset_out: got %h/%b want 0/0", out_data, out_mask); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pass();
    bit acc; int lat; logic [OW-1:0] o; logic [N-1:0] m; logic [N+OW-1:0] e;
    send_one(2'd0, 4'd0, '0, BASE_IN, acc, lat, o, m, e);
    n_checks++; if (acc !== 1'b1 || lat != 2) begin n_fail++; $display("[TB] FAIL pass_latency: got acc=%0b lat=%0d want acc=1 lat=2", acc, lat); end
    n_checks++; if ({m, o} !== {4'b1111, 32'h03020104}) begin n_fail++; $display("[TB] FAIL pass_out: got %h/%b want 03020104/1111", o, m); end
  endtask

  task automatic test_rotate();
    logic [DW_POS-1:0] cols [3] = '{4'd1, 4'd5, 4'd0};
    logic [OW-1:0]     exps [3] = '{32'h04030201, 32'h04030201, 32'h03020104};
    bit acc; int lat; logic [OW-1:0] o; logic [N-1:0] m; logic [N+OW-1:0] e;
    for (int t = 0; t < 3; t++) begin
      send_one(2'd1, cols[t], '0, BASE_IN, acc, lat, o, m, e);
      n_checks++;
      if (acc !== 1'b1 || lat != 2 || {m, o} !== {4'b1111, exps[t]}) begin
        n_fail++;
        $display("[TB] FAIL rotate_col%0d: got acc=%0b lat=%0d %h/%b want acc=1 lat=2 %h/1111", cols[t], acc, lat, o, m, exps[t]);
      end
    end
  endtask

  task automatic test_gather();
    bit acc; int lat; logic [OW-1:0] o; logic [N-1:0] m; logic [N+OW-1:0] e;
    send_one(2'd2, 4'd0, 16'h0533, BASE_IN, acc, lat, o, m, e);
    n_checks++; if (acc !== 1'b1 || lat != 2) begin n_fail++; $display("[TB] FAIL gather_latency: got acc=%0b lat=%0d want acc=1 lat=2", acc, lat); end
    n_checks++; if ({m, o} !== {4'b1011, 32'h04000303}) begin n_fail++; $display("[TB] FAIL gather_out: got %h/%b want 04000303/1011", o, m); end
  endtask

  task automatic test_broadcast();
    logic [DW_POS-1:0] cols  [2] = '{4'd2, 4'd7};
    logic [OW-1:0]     exps  [2] = '{32'h02020202, 32'h00000000};
    logic [N-1:0]      masks [2] = '{4'b1111, 4'b0000};
    bit acc; int lat; logic [OW-1:0] o; logic [N-1:0] m; logic [N+OW-1:0] e;
    for (int t = 0; t < 2; t++) begin
      send_one(2'd3, cols[t], '0, BASE_IN, acc, lat, o, m, e);
      n_checks++;
      if (acc !== 1'b1 || lat != 2 || {m, o} !== {masks[t], exps[t]}) begin
        n_fail++;
        $display("[TB] FAIL bcast_col%0d: got acc=%0b lat=%0d %h/%b want acc=1 lat=2 %h/%b", cols[t], acc, lat, o, m, exps[t], masks[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ov; logic [OW-1:0] so; logic [N-1:0] sm; logic [N+OW-1:0] e;
    int acc_cnt, drained, first, last;
    exp_q.delete();
    acc_cnt = 0; drained = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int s = 0; s < 14 && drained < 6; s++) begin
      in_valid = (s < 6);
      randomize_inputs();
      step(acc, ov, so, sm);
      if (acc) acc_cnt++;
      if (ov) begin
        if (first < 0) first = s;
        last = s;
        drained++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++; if ({sm, so} !== e) begin n_fail++; $display("[TB] FAIL b2b_beat%0d: got %h/%b want %h/%b", drained, so, sm, e[OW-1:0], e[N+OW-1:OW]); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc_cnt != 6 || drained != 6 || first != 2 || last - first != 5) begin
      n_fail++;
      $display("[TB] FAIL b2b_rate: got acc=%0d out=%0d first=%0d last=%0d want 6 6 2 7", acc_cnt, drained, first, last);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] bm [4]; logic [DW_POS-1:0] bc [4]; logic [XW-1:0] bx [4]; logic [IW-1:0] bd [4];
    logic acc, ov; logic [OW-1:0] so; logic [N-1:0] sm; logic [N+OW-1:0] e;
    int bi, drained, consec;
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      randomize_inputs();
      bm[b] = mode; bc[b] = col; bx[b] = idx; bd[b] = in_data;
    end
    bi = 0;
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1;
      mode = bm[bi]; col = bc[bi]; idx = bx[bi]; in_data = bd[bi];
      step(acc, ov, so, sm);
      if (acc) bi++;
    end
    #1;
    n_checks++; if (bi != 2) begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d want 2", bi); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
    e = (exp_q.size() > 0) ? exp_q[0] : '1;
    n_checks++;
    if (out_valid !== 1'b1 || {out_mask, out_data} !== e) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: got v=%b %h/%b want v=1 %h/%b", out_valid, out_data, out_mask, e[OW-1:0], e[N+OW-1:OW]);
    end
    for (int s = 0; s < 2; s++) begin
      step(acc, ov, so, sm);
      if (acc) bi++;
      n_checks++; if (ov !== 1'b1 || {sm, so} !== e) begin n_fail++; $display("[TB] FAIL bp_stable%0d: got v=%b %h/%b want v=1 %h/%b", s, ov, so, sm, e[OW-1:0], e[N+OW-1:OW]); end
    end
    out_ready = 1'b1;
    drained = 0; consec = 0;
    for (int s = 0; s < 10 && drained < 4; s++) begin
      in_valid = (bi < 4);
      if (bi < 4) begin mode = bm[bi]; col = bc[bi]; idx = bx[bi]; in_data = bd[bi]; end
      step(acc, ov, so, sm);
      if (acc) bi++;
      if (ov) begin
        drained++;
        if (s < 4) consec++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++; if ({sm, so} !== e) begin n_fail++; $display("[TB] FAIL bp_order%0d: got %h/%b want %h/%b", drained, so, sm, e[OW-1:0], e[N+OW-1:OW]); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (drained != 4 || consec != 4 || bi != 4) begin
      n_fail++;
      $display("[TB] FAIL bp_drain: got out=%0d consec=%0d acc=%0d want 4 4 4", drained, consec, bi);
    end
  endtask

  task automatic test_random();
    logic acc, ov; logic [OW-1:0] so; logic [N-1:0] sm; logic [N+OW-1:0] e;
    logic prev_stall; logic [OW-1:0] prev_o; logic [N-1:0] prev_m;
    int drained;
    exp_q.delete();
    prev_stall = 1'b0; prev_o = '0; prev_m = '0; drained = 0;
    for (int s = 0; s < 420; s++) begin
      if (s < 400) begin
        randomize_inputs();
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      step(acc, ov, so, sm);
      if (prev_stall) begin
        n_checks++;
        if (ov !== 1'b1 || so !== prev_o || sm !== prev_m) begin
          n_fail++;
          $display("[TB] FAIL rand_stall_s%0d: got v=%b %h/%b want v=1 %h/%b", s, ov, so, sm, prev_o, prev_m);
        end
      end
      if (ov && out_ready) begin
        drained++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL rand_extra_s%0d: got %h/%b want no beat", s, so, sm);
        end else begin
          e = exp_q.pop_front();
          if ({sm, so} !== e) begin n_fail++; $display("[TB] FAIL rand_beat_s%0d: got %h/%b want %h/%b", s, so, sm, e[OW-1:0], e[N+OW-1:OW]); end
        end
      end
      prev_stall = ov && !out_ready;
      prev_o = so;
      prev_m = sm;
    end
    n_checks++; if (exp_q.size() != 0 || drained == 0) begin n_fail++; $display("[TB] FAIL rand_leftover: got pending=%0d drained=%0d want pending=0 drained>0", exp_q.size(), drained); end
  endtask

  task automatic test_reset_midstream();
    logic acc, ov; logic [OW-1:0] so; logic [N-1:0] sm;
    bit acc_ok; int lat; logic [OW-1:0] o; logic [N-1:0] m; logic [N+OW-1:0] e;
    int acc_cnt;
    exp_q.delete();
    acc_cnt = 0;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      randomize_inputs();
      step(acc, ov, so, sm);
      if (acc) acc_cnt++;
    end
    n_checks++; if (acc_cnt != 2) begin n_fail++; $display("[TB] FAIL rst_fill: got %0d want 2", acc_cnt); end
    in_valid = 1'b0;
    rst = 1'b1;
    step(acc, ov, so, sm);
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || {out_mask, out_data} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_out: got v=%b %h/%b rdy=%b want v=0 0/0 rdy=1", out_valid, out_data, out_mask, in_ready);
    end
    randomize_inputs();
    send_one(mode, col, idx, in_data, acc_ok, lat, o, m, e);
    n_checks++;
    if (acc_ok !== 1'b1 || lat != 2 || {m, o} !== e) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_new: got acc=%0b lat=%0d %h/%b want acc=1 lat=2 %h/%b", acc_ok, lat, o, m, e[OW-1:0], e[N+OW-1:OW]);
    end
  endtask

  // Scenario sequence
  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 2'd0; col = '0; idx = '0; in_data = '0;
    test_reset();
    test_pass();
    test_rotate();
    test_gather();
    test_broadcast();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
